// File: rtl/store_lane_sequencer_pkg.sv
// Shared encodings for the store lane sequencer: access sizes, store opcodes and FSM states.
package store_lane_sequencer_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [2:0] SB_OP = 3'b000;
  localparam logic [2:0] SH_OP = 3'b001;
  localparam logic [2:0] SW_OP = 3'b010;
  localparam logic [2:0] SD_OP = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B0   = 2'd1,
    B1   = 2'd2
  } seqState_e;

  // Decoder helper: store funct3 to access size
  function automatic logic [1:0] storeOpToSize(input logic [2:0] op);
    case (op)
      SB_OP:   return SZ_B;
      SH_OP:   return SZ_H;
      SW_OP:   return SZ_W;
      default: return SZ_D;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_calc.sv
// Combinational lane math: double-width byte mask and shifted data for a store,
// plus the aligned base address and split/illegal classification.
module store_lane_calc
  import store_lane_sequencer_pkg::*;
#(
  parameter int unsigned DW          = 32,
  parameter int unsigned AW          = 32,
  parameter bit          ALLOW_SPLIT = 1'b1,
  localparam int unsigned NB         = DW / 8,
  localparam int unsigned OW         = $clog2(NB)
) (
  input  logic [1:0]      size_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW-1:0]   wdata_i,
  output logic [2*NB-1:0] mask2_o,
  output logic [2*DW-1:0] data2_o,
  output logic [AW-1:0]   base_o,
  output logic            split_o,
  output logic            illegal_o
);

  localparam bit DWORD_OK = (NB >= 8);

  logic [OW-1:0]   off;
  logic [2*NB-1:0] sizeMask;
  logic [DW-1:0]   dataMask;

  assign off = addr_i[OW-1:0];

  always_comb begin
    sizeMask = '0;
    case (size_i)
      SZ_B:    sizeMask = (2*NB)'(4'h1);
      SZ_H:    sizeMask = (2*NB)'(4'h3);
      SZ_W:    sizeMask = (2*NB)'(4'hF);
      default: sizeMask = (2*NB)'(8'hFF);
    endcase
  end

  // Expand the unshifted byte mask to bit granularity so data beyond n bytes is dropped
  always_comb begin
    dataMask = '0;
    for (int i = 0; i < int'(NB); i++) begin
      dataMask[8*i +: 8] = {8{sizeMask[i]}};
    end
  end

  assign mask2_o   = sizeMask << off;
  assign data2_o   = {{DW{1'b0}}, wdata_i & dataMask} << {off, 3'b000};
  assign base_o    = {addr_i[AW-1:OW], {OW{1'b0}}};
  assign split_o   = |mask2_o[2*NB-1:NB];
  assign illegal_o = ((size_i == SZ_D) && !DWORD_OK) || (split_o && !ALLOW_SPLIT);

endmodule

// File: rtl/store_lane_sequencer.sv
// Store path between M-stage and data bus: issues one or two lane-aligned beats per
// store over a valid/ready handshake, or a one-cycle err pulse for illegal requests.
module store_lane_sequencer
  import store_lane_sequencer_pkg::*;
#(
  parameter int unsigned DW          = 32,
  parameter int unsigned AW          = 32,
  parameter bit          ALLOW_SPLIT = 1'b1,
  localparam int unsigned NB         = DW / 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_size,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [NB-1:0] mem_byteen,
  output logic          err,
  output logic [AW-1:0] err_addr
);

  logic [2*NB-1:0] mask2;
  logic [2*DW-1:0] data2;
  logic [AW-1:0]   base;
  logic            split;
  logic            illegal;

  store_lane_calc #(
    .DW          (DW),
    .AW          (AW),
    .ALLOW_SPLIT (ALLOW_SPLIT)
  ) u_calc (
    .size_i    (req_size),
    .addr_i    (req_addr),
    .wdata_i   (req_wdata),
    .mask2_o   (mask2),
    .data2_o   (data2),
    .base_o    (base),
    .split_o   (split),
    .illegal_o (illegal)
  );

  seqState_e     state_q;
  logic          memValid_q;
  logic [AW-1:0] memAddr_q;
  logic [DW-1:0] memWdata_q;
  logic [NB-1:0] memByteen_q;
  logic [AW-1:0] b1Addr_q;
  logic [DW-1:0] b1Wdata_q;
  logic [NB-1:0] b1Byteen_q;
  logic          splitPend_q;
  logic          err_q;
  logic [AW-1:0] errAddr_q;

  logic lastBeat;
  logic accept;

  // Ready combinationally follows mem_ready so a finishing beat can overlap the next accept
  assign lastBeat  = ((state_q == B0) && !splitPend_q) || (state_q == B1);
  assign req_ready = (state_q == IDLE) || (lastBeat && memValid_q && mem_ready);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      memValid_q  <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      memByteen_q <= '0;
      b1Addr_q    <= '0;
      b1Wdata_q   <= '0;
      b1Byteen_q  <= '0;
      splitPend_q <= 1'b0;
      err_q       <= 1'b0;
      errAddr_q   <= '0;
    end else begin
      err_q <= 1'b0;
      if (accept) begin
        if (illegal) begin
          state_q    <= IDLE;
          memValid_q <= 1'b0;
          err_q      <= 1'b1;
          errAddr_q  <= req_addr;
        end else begin
          state_q     <= B0;
          memValid_q  <= 1'b1;
          memAddr_q   <= base;
          memWdata_q  <= data2[DW-1:0];
          memByteen_q <= mask2[NB-1:0];
          b1Addr_q    <= base + AW'(NB);
          b1Wdata_q   <= data2[2*DW-1:DW];
          b1Byteen_q  <= mask2[2*NB-1:NB];
          splitPend_q <= split;
        end
      end else if (memValid_q && mem_ready) begin
        if ((state_q == B0) && splitPend_q) begin
          state_q     <= B1;
          memAddr_q   <= b1Addr_q;
          memWdata_q  <= b1Wdata_q;
          memByteen_q <= b1Byteen_q;
          splitPend_q <= 1'b0;
        end else begin
          state_q    <= IDLE;
          memValid_q <= 1'b0;
        end
      end
    end
  end

  assign mem_valid  = memValid_q;
  assign mem_addr   = memAddr_q;
  assign mem_wdata  = memWdata_q;
  assign mem_byteen = memByteen_q;
  assign err        = err_q;
  assign err_addr   = errAddr_q;

endmodule

// File: tb/tb_store_lane_sequencer.sv
// Scoreboard bench for store_lane_sequencer: 32-bit split, 32-bit no-split and 64-bit instances
// driven from one stimulus thread, with a byte-loop reference model predicting beats and errors.
module tb_store_lane_sequencer;
  import store_lane_sequencer_pkg::*;

  logic clk = 1'b0;
  logic resetN;

  logic        reqValidA, reqReadyA, memValidA, memReadyA, errA;
  logic [1:0]  reqSizeA;
  logic [31:0] reqAddrA, reqWdataA, memAddrA, memWdataA, errAddrA;
  logic [3:0]  memByteenA;

  logic        reqValidB, reqReadyB, memValidB, memReadyB, errB;
  logic [1:0]  reqSizeB;
  logic [31:0] reqAddrB, reqWdataB, memAddrB, memWdataB, errAddrB;
  logic [3:0]  memByteenB;

  logic        reqValidC, reqReadyC, memValidC, memReadyC, errC;
  logic [1:0]  reqSizeC;
  logic [31:0] reqAddrC, memAddrC, errAddrC;
  logic [63:0] reqWdataC, memWdataC;
  logic [7:0]  memByteenC;

  store_lane_sequencer #(.DW(32), .AW(32), .ALLOW_SPLIT(1'b1)) dutA (
    .clk(clk), .reset(resetN), .req_valid(reqValidA), .req_ready(reqReadyA),
    .req_size(reqSizeA), .req_addr(reqAddrA), .req_wdata(reqWdataA),
    .mem_valid(memValidA), .mem_ready(memReadyA), .mem_addr(memAddrA),
    .mem_wdata(memWdataA), .mem_byteen(memByteenA), .err(errA), .err_addr(errAddrA)
  );

  store_lane_sequencer #(.DW(32), .AW(32), .ALLOW_SPLIT(1'b0)) dutB (
    .clk(clk), .reset(resetN), .req_valid(reqValidB), .req_ready(reqReadyB),
    .req_size(reqSizeB), .req_addr(reqAddrB), .req_wdata(reqWdataB),
    .mem_valid(memValidB), .mem_ready(memReadyB), .mem_addr(memAddrB),
    .mem_wdata(memWdataB), .mem_byteen(memByteenB), .err(errB), .err_addr(errAddrB)
  );

  store_lane_sequencer #(.DW(64), .AW(32), .ALLOW_SPLIT(1'b1)) dutC (
    .clk(clk), .reset(resetN), .req_valid(reqValidC), .req_ready(reqReadyC),
    .req_size(reqSizeC), .req_addr(reqAddrC), .req_wdata(reqWdataC),
    .mem_valid(memValidC), .mem_ready(memReadyC), .mem_addr(memAddrC),
    .mem_wdata(memWdataC), .mem_byteen(memByteenC), .err(errC), .err_addr(errAddrC)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } beat_t;

  beat_t       expA[$], expB[$], expC[$];
  logic [31:0] errExpA[$], errExpB[$], errExpC[$];

  int assertCount = 0;
  int failCount   = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic int pending();
    return expA.size() + expB.size() + expC.size() + errExpA.size() + errExpB.size() + errExpC.size();
  endfunction

  function automatic logic readyOf(input int dut);
    case (dut)
      0:       return reqReadyA;
      1:       return reqReadyB;
      default: return reqReadyC;
    endcase
  endfunction

  // Reference model: place each store byte into its lane one at a time
  task automatic predict(input int dut, input logic [1:0] size, input logic [31:0] addr,
                         input logic [63:0] data);
    int nb;
    int n;
    int off;
    bit allowSplit;
    bit need1;
    bit bad;
    beat_t b0;
    beat_t b1;
    nb         = (dut == 2) ? 8 : 4;
    allowSplit = (dut != 1);
    n          = 1 << size;
    off        = int'(addr[2:0]) & (nb - 1);
    b0.addr    = addr & ~(32'(nb) - 32'd1);
    b0.data    = '0;
    b0.be      = '0;
    b1.addr    = b0.addr + 32'(nb);
    b1.data    = '0;
    b1.be      = '0;
    need1      = 1'b0;
    bad        = (n > nb);
    if (!bad) begin
      for (int i = 0; i < n; i++) begin
        int lane;
        lane = off + i;
        if (lane < nb) begin
          b0.data[8*lane +: 8] = data[8*i +: 8];
          b0.be[lane]          = 1'b1;
        end else begin
          b1.data[8*(lane-nb) +: 8] = data[8*i +: 8];
          b1.be[lane-nb]            = 1'b1;
          need1                     = 1'b1;
        end
      end
    end
    if (need1 && !allowSplit) bad = 1'b1;
    if (bad) begin
      case (dut)
        0:       errExpA.push_back(addr);
        1:       errExpB.push_back(addr);
        default: errExpC.push_back(addr);
      endcase
    end else begin
      case (dut)
        0: begin expA.push_back(b0); if (need1) expA.push_back(b1); end
        1: begin expB.push_back(b0); if (need1) expB.push_back(b1); end
        default: begin expC.push_back(b0); if (need1) expC.push_back(b1); end
      endcase
    end
  endtask

  // Present one request, wait for acceptance, return the number of stalled cycles
  task automatic applyStimulus(input int dut, input logic [1:0] size, input logic [31:0] addr,
                               input logic [63:0] data, output int waits);
    bit got;
    case (dut)
      0: begin reqValidA = 1'b1; reqSizeA = size; reqAddrA = addr; reqWdataA = data[31:0]; end
      1: begin reqValidB = 1'b1; reqSizeB = size; reqAddrB = addr; reqWdataB = data[31:0]; end
      default: begin reqValidC = 1'b1; reqSizeC = size; reqAddrC = addr; reqWdataC = data; end
    endcase
    predict(dut, size, addr, data);
    waits = 0;
    got   = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = readyOf(dut);
      if (!got) waits++;
    end
    if (!got) checkOutput("accept_timeout", 64'(got), 64'd1);
    @(posedge clk);
    #1;
    reqValidA = 1'b0;
    reqValidB = 1'b0;
    reqValidC = 1'b0;
  endtask

  task automatic drainAll(input string tag);
    for (int k = 0; k < 40; k++) begin
      if (pending() == 0) break;
      @(negedge clk);
      #1;
    end
    checkOutput(tag, 64'(pending()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors, sampled on the falling edge while a handshake is set up
  always @(negedge clk) begin
    beat_t e;
    if (resetN && memValidA && memReadyA) begin
      if (expA.size() == 0) checkOutput("A_unexpected_beat", 64'd1, 64'd0);
      else begin
        e = expA.pop_front();
        checkOutput("A_addr", 64'(memAddrA), 64'(e.addr));
        checkOutput("A_wdata", 64'(memWdataA), e.data);
        checkOutput("A_byteen", 64'(memByteenA), 64'(e.be));
      end
    end
    if (resetN && memValidB && memReadyB) begin
      if (expB.size() == 0) checkOutput("B_unexpected_beat", 64'd1, 64'd0);
      else begin
        e = expB.pop_front();
        checkOutput("B_addr", 64'(memAddrB), 64'(e.addr));
        checkOutput("B_wdata", 64'(memWdataB), e.data);
        checkOutput("B_byteen", 64'(memByteenB), 64'(e.be));
      end
    end
    if (resetN && memValidC && memReadyC) begin
      if (expC.size() == 0) checkOutput("C_unexpected_beat", 64'd1, 64'd0);
      else begin
        e = expC.pop_front();
        checkOutput("C_addr", 64'(memAddrC), 64'(e.addr));
        checkOutput("C_wdata", memWdataC, e.data);
        checkOutput("C_byteen", 64'(memByteenC), 64'(e.be));
      end
    end
  end

  always @(negedge clk) begin
    if (resetN && errA) begin
      if (errExpA.size() == 0) checkOutput("A_unexpected_err", 64'd1, 64'd0);
      else checkOutput("A_err_addr", 64'(errAddrA), 64'(errExpA.pop_front()));
    end
    if (resetN && errB) begin
      if (errExpB.size() == 0) checkOutput("B_unexpected_err", 64'd1, 64'd0);
      else checkOutput("B_err_addr", 64'(errAddrB), 64'(errExpB.pop_front()));
    end
    if (resetN && errC) begin
      if (errExpC.size() == 0) checkOutput("C_unexpected_err", 64'd1, 64'd0);
      else checkOutput("C_err_addr", 64'(errAddrC), 64'(errExpC.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    reqValidA = 1'b0; reqSizeA = '0; reqAddrA = '0; reqWdataA = '0; memReadyA = 1'b1;
    reqValidB = 1'b0; reqSizeB = '0; reqAddrB = '0; reqWdataB = '0; memReadyB = 1'b1;
    reqValidC = 1'b0; reqSizeC = '0; reqAddrC = '0; reqWdataC = '0; memReadyC = 1'b1;
    resetN = 1'b0;
    #2;
    checkOutput("rst_A_valid", 64'(memValidA), 64'd0);
    checkOutput("rst_A_addr", 64'(memAddrA), 64'd0);
    checkOutput("rst_A_wdata", 64'(memWdataA), 64'd0);
    checkOutput("rst_A_byteen", 64'(memByteenA), 64'd0);
    checkOutput("rst_A_err", 64'(errA), 64'd0);
    checkOutput("rst_A_err_addr", 64'(errAddrA), 64'd0);
    checkOutput("rst_A_req_ready", 64'(reqReadyA), 64'd1);
    checkOutput("rst_C_valid", 64'(memValidC), 64'd0);
    checkOutput("rst_C_byteen", 64'(memByteenC), 64'd0);
    #20;
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] aligned and sub-word stores on 32-bit lane");
    applyStimulus(0, SZ_W, 32'h100, 64'hDEADBEEF, w);
    checkOutput("sw_latency_valid", 64'(memValidA), 64'd1);
    checkOutput("sw_latency_addr", 64'(memAddrA), 64'h100);
    checkOutput("sw_latency_be", 64'(memByteenA), 64'hF);
    applyStimulus(0, SZ_B, 32'h203, 64'h000000AB, w);
    checkOutput("sb_no_wait", 64'(w), 64'd0);
    applyStimulus(0, SZ_H, 32'h202, 64'hFFFF1234, w);
    drainAll("drain_subword");

    $display("[TB] split store and split cost");
    applyStimulus(0, SZ_W, 32'h1FE, 64'h11223344, w);
    applyStimulus(0, SZ_W, 32'h300, 64'h55667788, w);
    checkOutput("split_cost", 64'(w), 64'd1);
    drainAll("drain_split");

    $display("[TB] illegal requests");
    applyStimulus(1, SZ_W, 32'h1FE, 64'h11223344, w);
    checkOutput("B_err_pulse", 64'(errB), 64'd1);
    checkOutput("B_err_addr_now", 64'(errAddrB), 64'h1FE);
    checkOutput("B_no_valid", 64'(memValidB), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("B_err_one_cycle", 64'(errB), 64'd0);
    applyStimulus(1, SZ_W, 32'h40, 64'hCAFEF00D, w);
    applyStimulus(0, SZ_D, 32'h44, 64'h0123456789ABCDEF, w);
    checkOutput("A_dword_err", 64'(errA), 64'd1);
    checkOutput("A_dword_no_valid", 64'(memValidA), 64'd0);
    drainAll("drain_illegal");

    $display("[TB] address wrap");
    applyStimulus(0, SZ_W, 32'hFFFFFFFE, 64'hA1B2C3D4, w);
    drainAll("drain_wrap");

    $display("[TB] 64-bit stall then streaming byte stores");
    memReadyC = 1'b0;
    applyStimulus(2, SZ_D, 32'h8, 64'h0102030405060708, w);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("stall_valid", 64'(memValidC), 64'd1);
      checkOutput("stall_byteen", 64'(memByteenC), 64'hFF);
      checkOutput("stall_addr", 64'(memAddrC), 64'h8);
      checkOutput("stall_wdata", memWdataC, 64'h0102030405060708);
      checkOutput("stall_req_ready", 64'(reqReadyC), 64'd0);
      @(posedge clk);
      #1;
    end
    memReadyC = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2, SZ_B, 32'h20 + 32'(k), 64'(8'h11 * (k + 1)), w);
      checkOutput("stream_no_wait", 64'(w), 64'd0);
    end
    applyStimulus(2, SZ_W, 32'hC, 64'h89ABCDEF, w);
    applyStimulus(2, SZ_D, 32'hA, 64'hF0E1D2C3B4A59687, w);
    drainAll("drain_c");

    $display("[TB] reset during pending second beat");
    applyStimulus(0, SZ_W, 32'h1FE, 64'h11223344, w);
    @(posedge clk);
    #1;
    memReadyA = 1'b0;
    #1;
    checkOutput("rst_mid_valid_before", 64'(memValidA), 64'd1);
    checkOutput("rst_mid_be_before", 64'(memByteenA), 64'h3);
    resetN = 1'b0;
    #1;
    checkOutput("rst_mid_valid", 64'(memValidA), 64'd0);
    checkOutput("rst_mid_byteen", 64'(memByteenA), 64'd0);
    checkOutput("rst_mid_addr", 64'(memAddrA), 64'd0);
    checkOutput("rst_mid_req_ready", 64'(reqReadyA), 64'd1);
    expA.delete();
    @(negedge clk);
    resetN    = 1'b1;
    memReadyA = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(0, SZ_H, 32'h12, 64'h0000BEEF, w);
    checkOutput("post_rst_valid", 64'(memValidA), 64'd1);
    checkOutput("post_rst_addr", 64'(memAddrA), 64'h10);
    drainAll("drain_post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/store_lane_sequencer.md
# store_lane_sequencer

Parametrised store-path block between the M-stage and the data-memory bus. It turns a store request (size, byte address, unshifted data) into one or two lane-aligned bus beats with per-byte write enables and correctly shifted write data. Misaligned accesses that cross a bus word are split into two beats when splitting is enabled, and flagged as an error when it is not. Beats leave through a valid/ready handshake, so memory back-pressure stalls the pipeline through `req_ready`.

## Interface
Parameters:
- `DW`, 32: bus data width in bits, 32 or 64; `NB = DW/8` byte lanes, `OW = log2(NB)`.
- `AW`, 32: byte-address width.
- `ALLOW_SPLIT`, 1: 1 means crossing stores become two beats; 0 means they raise `err`.

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low.
- `req_valid` input 1: store request present.
- `req_ready` output 1: request accepted this cycle when high together with `req_valid`.
- `req_size` input 2: 0 byte, 1 half, 2 word, 3 dword (dword legal only when `DW=64`).
- `req_addr` input AW: byte address.
- `req_wdata` input DW: store data, LSB-justified.
- `mem_valid` output 1: beat present.
- `mem_ready` input 1: memory accepts the beat.
- `mem_addr` output AW: beat address, low `OW` bits always 0.
- `mem_wdata` output DW: lane-shifted data.
- `mem_byteen` output NB: byte enables, never all-zero while `mem_valid`.
- `err` output 1: one-cycle pulse for an illegal or unsplittable request.
- `err_addr` output AW: `req_addr` of the faulting request, valid with `err`.

## Operation
- `off = req_addr[OW-1:0]`; `n = 1 << req_size`.
- Mask: `mask2 = ((1<<n)-1) << off`, width 2*NB. Data: `data2 = req_wdata` masked to n bytes, shifted left by `8*off`, width 2*DW.
- Base address: `base = req_addr` with low OW bits cleared.
- Beat0: `base`, `mask2[NB-1:0]`, `data2[DW-1:0]`.
- Beat1 exists only if `mask2[2NB-1:NB]` is nonzero. It uses `base+NB` (mod 2^AW), the upper mask half and `data2[2DW-1:DW]`.
- Illegal request: `req_size==3` with `DW=32`, or beat1 required with `ALLOW_SPLIT=0`. It is accepted normally, produces no beat, and sets `err`/`err_addr` the cycle after acceptance.
- FSM states:
  - IDLE goes to B0 on a legal accept. On an illegal accept it stays in IDLE and pulses `err`.
  - B0 holds while `mem_ready=0`. On handshake it goes to B1 if a split is pending, otherwise to IDLE, or to B0 again on a back-to-back accept.
  - B1 holds until handshake, then goes to IDLE or B0 on a back-to-back accept.
- `req_ready = (state==IDLE) | (last beat & mem_valid & mem_ready)`. This combinational path from `mem_ready` is intentional.
- Beat1 contents are registered at accept time, not recomputed.

## Timing
- Reset values: `mem_valid=0`, `mem_addr=0`, `mem_wdata=0`, `mem_byteen=0`, `err=0`, `err_addr=0`, state IDLE. `req_ready` is 1 out of reset.
- Latency: accept at edge T, so beat0 `mem_valid` is high in cycle T+1. Beat1 is valid the cycle after beat0's handshake.
- Throughput: one unsplit store per cycle with `mem_ready` held high. A split store costs 2 cycles.
- While `mem_valid=1` and `mem_ready=0`, `mem_addr`, `mem_wdata` and `mem_byteen` hold stable.
- An `err` pulse lasts exactly one cycle and never overlaps a beat from the same request.
- Address wrap: beat1 of a store at the top lane of the address space targets address 0.
- If reset asserts mid-transaction, the pending beat(s) are dropped and the block returns to reset values immediately. No partial-beat completion.

## Structure
- Shared package holds:
  - Size encodings `SZ_B`, `SZ_H`, `SZ_W`, `SZ_D`.
  - The store-opcode-to-size mapping used by the decoder (`SB_OP`, `SH_OP`, `SW_OP` map to `SZ_B`, `SZ_H`, `SZ_W`).
  - The FSM state enum.
- One combinational sub-module `store_lane_calc` computes `mask2`, `data2`, `base`, `split` and `illegal` from size, address and data. The top level holds the FSM and output registers.

## Test plan
- DW=32, SW at 0x100, data 0xDEADBEEF, `mem_ready=1`: one beat at 0x100, byteen 1111, wdata 0xDEADBEEF, cycle after accept.
- DW=32, SB at 0x203, data 0x000000AB: beat at 0x200, byteen 1000, wdata 0xAB000000. Repeat with SH at 0x202 and data 0x1234: byteen 1100, wdata 0x12340000.
- DW=32, ALLOW_SPLIT=1, SW at 0x1FE, data 0x11223344: beat0 0x1FC, byteen 1100, wdata 0x33440000; beat1 0x200, byteen 0011, wdata 0x00001122.
- Same request with ALLOW_SPLIT=0: no `mem_valid`, single `err` pulse with `err_addr=0x1FE`.
- DW=64, SD at 0x8, `mem_ready` low for 3 cycles: `mem_valid` and byteen 0xFF held stable, `req_ready=0` throughout; 4 back-to-back SBs then stream at one per cycle.
- Split store in flight (beat0 done, beat1 waiting): assert `reset` asynchronously, which forces `mem_valid` low at once; after release the first new store issues normally.
